spwm_gate_modulator: RTL and testbench
======================================

Name: spwm_gate_modulator

Overview:
- Consumer end of the triangular carrier: compares a sampled sine reference against the 16-bit up/down carrier count.
- Produces complementary high/low-side gate signals with dead-time insertion.
- Sits between the carrier generator and the inverter gate-driver pins, one instance per phase leg.
- Reference samples arrive from an upstream sine table over a valid/ready handshake.

Parameters:
- WIDTH, 16, carrier and reference width (unsigned, 0..2^WIDTH-1).
- DEAD_CYCLES, 50, clk cycles both gates held low on every transition (1 us at 50 MHz); legal range 1..255.
- DT_W, 8, width of the dead-time counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  modulation enable; low forces both gates off.
- carrier  in  WIDTH  triangular carrier count from the carrier generator.
- carrier_dir  in  1  carrier direction, 0 = counting up, 1 = counting down.
- ref_valid  in  1  upstream reference sample valid.
- ref_data  in  WIDTH  reference sample, unsigned offset-binary (midscale = 0 V).
- ref_ready  out  1  block requests/accepts a new reference sample.
- gate_hi  out  1  high-side gate drive.
- gate_lo  out  1  low-side gate drive.
- underrun  out  1  sticky flag: no valid sample at an update point.
- underrun_clr  in  1  synchronous clear of underrun.

Behaviour:
- Reset values: gate_hi=0, gate_lo=0, ref_ready=0, underrun=0, ref_q=midscale (2^(WIDTH-1)), FSM=OFF, dt counter=0.
- Update point (valley):
  - carrier_dir registered each cycle; valley event = registered dir 1 and current dir 0.
  - Valley event sets ref_ready=1 the following cycle.
- Handshake:
  - Transfer occurs on any cycle with ref_valid && ref_ready.
  - On transfer, ref_q <= ref_data and ref_ready drops the next cycle.
  - ref_ready stays high until a transfer or the next update point.
  - If the next update point arrives with ref_ready still high: underrun set, ref_q unchanged, ref_ready stays high.
  - ref_valid outside ref_ready is ignored.
- Compare: demand = (ref_q > carrier), registered (1 cycle). ref_q == carrier yields demand 0.
- Gate FSM states:
  - OFF: both gates low.
  - HI_ON: gate_hi=1.
  - DT_LO: both low, then low side turns on.
  - LO_ON: gate_lo=1.
  - DT_HI: both low, then high side turns on.
- Transitions:
  - OFF -> DT_HI if enable && demand; OFF -> DT_LO if enable && !demand.
  - HI_ON -> DT_LO when !demand.
  - LO_ON -> DT_HI when demand.
  - DT_x loads counter = DEAD_CYCLES on entry and decrements to 0. At 0: go to x_ON if demand still matches; otherwise jump to the opposite DT state and reload the counter.
  - gate_hi and gate_lo are never simultaneously 1 in any state (invariant).
- Latency: demand change to gate edge = 1 (compare register) + 1 (FSM) + DEAD_CYCLES cycles. Gate turn-off is 2 cycles after the demand change.
- enable low: next cycle FSM=OFF, both gates 0, dt counter cleared, ref_ready=0. Re-enable starts through a DT state, never directly to an ON state.
- underrun_clr has priority over a simultaneous new underrun event (clear wins).
- Asynchronous reset mid-pulse: gates drop immediately, without waiting for a clock.
- Carrier wrap is not expected. Values are compared as unsigned, with no modulo handling.

Optional Feature:
- Macro SPWM_DOUBLE_UPDATE_EN.
- Defined: peak events (registered dir 0, current dir 1) are also update points, giving asymmetric regular sampling. Reference is requested twice per carrier period, and underrun is checked at both points.
- Undefined: update at valley only (symmetric regular sampling). Peak logic is not synthesized.

Decomposition:
- Shared package spwm_pkg:
  - FSM state encoding (OFF, HI_ON, DT_LO, LO_ON, DT_HI).
  - Default WIDTH and DEAD_CYCLES constants.
  - Midscale constant.
- One natural sub-module, spwm_deadtime: owns the FSM and dead-time counter. Inputs: clk, rst_n, enable, demand. Outputs: gate_hi, gate_lo.
- Top-level keeps the update-point detect, handshake, ref_q register and comparator.

Test Plan:
1. Reset release with enable=1, ref_data=0x8000 valid at first ready, carrier sweeping 0..65535..0 -> gates alternate with ~50% duty. Every hi/lo transition has exactly 50 cycles of both low; gate_hi and gate_lo are never both 1.
2. Single-cycle demand dip where carrier exceeds ref_q for one cycle during HI_ON -> FSM goes HI_ON->DT_LO->DT_HI (bounce), and gate_lo is never asserted.
3. ref_valid held low across two valleys -> underrun=1 at the second valley and ref_q holds its old value. underrun_clr pulsed on the same cycle as a new event -> underrun reads 0.
4. enable dropped mid HI_ON -> gate_hi=0 one cycle later. Re-enable with demand=1 -> gate_hi rises only after 50 cycles in DT_HI.
5. Assert rst_n=0 asynchronously between clock edges during LO_ON -> gate_lo=0 before the next edge, and all outputs match the reset values.
6. With SPWM_DOUBLE_UPDATE_EN defined -> ref_ready pulses at both peak and valley, and ref_q updates twice per carrier period. Undefined -> valley only.

Source files
------------

// File: rtl/spwm_pkg.sv
// Shared types and constants for the SPWM gate modulator: gate FSM encoding,
// default widths and the offset-binary midscale reference.
package spwm_pkg;

  localparam int unsigned DefaultWidth      = 16;
  localparam int unsigned DefaultDeadCycles = 50;
  localparam int unsigned DefaultDtW        = 8;

  // Offset-binary zero volts for the default width.
  localparam logic [DefaultWidth-1:0] Midscale = {1'b1, {(DefaultWidth-1){1'b0}}};

  typedef enum logic [2:0] {
    StOff,
    StHiOn,
    StDtLo,
    StLoOn,
    StDtHi
  } gate_state_e;

endpackage

// File: rtl/spwm_deadtime.sv
// Gate FSM with dead-time insertion: each hi/lo handover holds both gates low
// for DEAD_CYCLES clocks.
module spwm_deadtime
  import spwm_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = DefaultDeadCycles,
  parameter int unsigned DT_W        = DefaultDtW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic demand,
  output logic gate_hi,
  output logic gate_lo
);

  localparam logic [DT_W-1:0] DeadLoad = DT_W'(DEAD_CYCLES);

  gate_state_e     state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d, cnt_dec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_dec = cnt_q - DT_W'(1);
    if (!enable) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = demand ? StDtHi : StDtLo;
          cnt_d   = DeadLoad;
        end
        StHiOn: begin
          if (!demand) begin
            state_d = StDtLo;
            cnt_d   = DeadLoad;
          end
        end
        StLoOn: begin
          if (demand) begin
            state_d = StDtHi;
            cnt_d   = DeadLoad;
          end
        end
        // Leave on the edge the count reaches zero so exactly DEAD_CYCLES
        // cycles are spent with both gates low.
        StDtHi: begin
          if (cnt_dec == '0) begin
            if (demand) begin
              state_d = StHiOn;
              cnt_d   = '0;
            end else begin
              state_d = StDtLo;
              cnt_d   = DeadLoad;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StDtLo: begin
          if (cnt_dec == '0) begin
            if (!demand) begin
              state_d = StLoOn;
              cnt_d   = '0;
            end else begin
              state_d = StDtHi;
              cnt_d   = DeadLoad;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded straight from the state register so reset drops the gates at once.
  assign gate_hi = (state_q == StHiOn);
  assign gate_lo = (state_q == StLoOn);

endmodule

// File: rtl/spwm_gate_modulator.sv
// Per-leg SPWM modulator: samples the reference at carrier update points and
// compares it to the carrier. SPWM_DOUBLE_UPDATE_EN adds peak update points.
module spwm_gate_modulator
  import spwm_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned DEAD_CYCLES = DefaultDeadCycles,
  parameter int unsigned DT_W        = DefaultDtW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] carrier,
  input  logic             carrier_dir,
  input  logic             ref_valid,
  input  logic [WIDTH-1:0] ref_data,
  output logic             ref_ready,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam logic [WIDTH-1:0] MidRef = {1'b1, {(WIDTH-1){1'b0}}};

  logic             dir_q;
  logic             ready_q, ready_d;
  logic             underrun_q, underrun_d;
  logic             demand_q;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             valley, update, xfer, underrun_evt;

  assign valley = dir_q & ~carrier_dir;

`ifdef SPWM_DOUBLE_UPDATE_EN
  logic peak;
  assign peak   = ~dir_q & carrier_dir;
  assign update = valley | peak;
`else
  assign update = valley;
`endif

  assign xfer         = ref_valid & ready_q;
  // A sample accepted on the update cycle itself counts as on time.
  assign underrun_evt = update & ready_q & ~xfer;

  always_comb begin
    ready_d    = ready_q;
    ref_d      = ref_q;
    underrun_d = underrun_q;
    if (xfer) begin
      ref_d = ref_data;
    end
    if (!enable) begin
      ready_d = 1'b0;
    end else if (update) begin
      ready_d = 1'b1;
    end else if (xfer) begin
      ready_d = 1'b0;
    end
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end else if (underrun_evt) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      ref_q      <= MidRef;
      demand_q   <= 1'b0;
    end else begin
      dir_q      <= carrier_dir;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      ref_q      <= ref_d;
      demand_q   <= (ref_q > carrier);
    end
  end

  assign ref_ready = ready_q;
  assign underrun  = underrun_q;

  spwm_deadtime #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .DT_W       (DT_W)
  ) u_deadtime (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .demand (demand_q),
    .gate_hi(gate_hi),
    .gate_lo(gate_lo)
  );

endmodule

// File: tb/tb_spwm_gate_modulator.sv
// Directed bench for spwm_gate_modulator; expectations follow
// SPWM_DOUBLE_UPDATE_EN when it is defined for the build.
module tb_spwm_gate_modulator;
  import spwm_pkg::*;

  localparam int DC = 50;
`ifdef SPWM_DOUBLE_UPDATE_EN
  localparam bit Dbl = 1'b1;
`else
  localparam bit Dbl = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] carrier = '0;
  logic        carrier_dir = 1'b0;
  logic        ref_valid = 1'b0;
  logic [15:0] ref_data = '0;
  logic        ref_ready;
  logic        gate_hi;
  logic        gate_lo;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spwm_gate_modulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .carrier     (carrier),
    .carrier_dir (carrier_dir),
    .ref_valid   (ref_valid),
    .ref_data    (ref_data),
    .ref_ready   (ref_ready),
    .gate_hi     (gate_hi),
    .gate_lo     (gate_lo),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #23;
    n_checks++; if (gate_hi !== 1'b0) $display("FAIL rst_gate_hi: got %b want 0", gate_hi); else n_pass++;
    n_checks++; if (gate_lo !== 1'b0) $display("FAIL rst_gate_lo: got %b want 0", gate_lo); else n_pass++;
    n_checks++; if (ref_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ref_ready); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (dut.ref_q !== 16'h8000) $display("FAIL rst_ref_q: got %h want 8000", dut.ref_q); else n_pass++;
    n_checks++; if (dut.u_deadtime.state_q !== StOff)
      $display("FAIL rst_state: got %0d want %0d", dut.u_deadtime.state_q, StOff); else n_pass++;
    n_checks++; if (dut.u_deadtime.cnt_q !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", dut.u_deadtime.cnt_q); else n_pass++;
  endtask

  // Triangle carrier in steps of 256: 256 cycles up, 256 cycles down per period.
  task automatic sweep(input int periods, output int hi, output int lo, output int dead,
                       output int gaps, output int bad, output int both);
    int  run;
    bit  armed;
    bit  prev_on;
    hi = 0; lo = 0; dead = 0; gaps = 0; bad = 0; both = 0;
    run = 0; armed = 1'b0; prev_on = 1'b1;
    for (int p = 0; p < periods; p++) begin
      for (int h = 0; h < 2; h++) begin
        for (int k = 0; k < 256; k++) begin
          if (h == 0) begin
            carrier = 16'(k * 256);
            carrier_dir = 1'b0;
          end else begin
            carrier = 16'(65535 - k * 256);
            carrier_dir = 1'b1;
          end
          tick(1);
          if (gate_hi && gate_lo) both++;
          if (gate_hi) hi++;
          if (gate_lo) lo++;
          if (gate_hi || gate_lo) begin
            if (armed) begin
              gaps++;
              if (run != DC) bad++;
            end
            armed = 1'b0;
            run = 0;
            prev_on = 1'b1;
          end else begin
            dead++;
            if (prev_on) begin
              armed = 1'b1;
              run = 0;
            end
            run++;
            prev_on = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic test_sweep();
    int hi, lo, dead, gaps, bad, both;
    enable = 1'b1;
    ref_valid = 1'b1;
    ref_data = 16'h8000;
    carrier = '0;
    carrier_dir = 1'b0;
    rst_n = 1'b1;
    sweep(1, hi, lo, dead, gaps, bad, both);
    sweep(2, hi, lo, dead, gaps, bad, both);
    n_checks++; if (both !== 0) $display("FAIL sweep_overlap: got %0d want 0", both); else n_pass++;
    n_checks++; if (hi !== 412) $display("FAIL sweep_hi_cycles: got %0d want 412", hi); else n_pass++;
    n_checks++; if (lo !== 412) $display("FAIL sweep_lo_cycles: got %0d want 412", lo); else n_pass++;
    n_checks++; if (dead !== 200) $display("FAIL sweep_dead_cycles: got %0d want 200", dead); else n_pass++;
    n_checks++; if (gaps !== 4) $display("FAIL sweep_gap_count: got %0d want 4", gaps); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL sweep_gap_len: got %0d bad gaps want 0", bad); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL sweep_underrun: got %b want 0", underrun); else n_pass++;
  endtask

  task automatic test_bounce();
    bit lo_seen;
    carrier = 16'h1000;
    carrier_dir = 1'b0;
    tick(3);
    ref_valid = 1'b0;
    tick(120);
    n_checks++; if (gate_hi !== 1'b1) $display("FAIL bounce_pre_hi: got %b want 1", gate_hi); else n_pass++;
    carrier = 16'h9000;
    tick(1);
    n_checks++; if (gate_hi !== 1'b1) $display("FAIL bounce_edge1_hi: got %b want 1", gate_hi); else n_pass++;
    carrier = 16'h1000;
    tick(1);
    n_checks++; if (gate_hi !== 1'b0) $display("FAIL bounce_turnoff: got %b want 0", gate_hi); else n_pass++;
    n_checks++; if (dut.u_deadtime.state_q !== StDtLo)
      $display("FAIL bounce_dtlo_entry: got %0d want %0d", dut.u_deadtime.state_q, StDtLo); else n_pass++;
    lo_seen = 1'b0;
    for (int j = 3; j <= 102; j++) begin
      tick(1);
      if (gate_lo) lo_seen = 1'b1;
      if (j == 51) begin
        n_checks++; if (dut.u_deadtime.state_q !== StDtLo)
          $display("FAIL bounce_dtlo_hold: got %0d want %0d", dut.u_deadtime.state_q, StDtLo); else n_pass++;
      end
      if (j == 52) begin
        n_checks++; if (dut.u_deadtime.state_q !== StDtHi)
          $display("FAIL bounce_to_dthi: got %0d want %0d", dut.u_deadtime.state_q, StDtHi); else n_pass++;
      end
      if (j == 101) begin
        n_checks++; if (gate_hi !== 1'b0) $display("FAIL bounce_dthi_hold: got %b want 0", gate_hi); else n_pass++;
      end
      if (j == 102) begin
        n_checks++; if (gate_hi !== 1'b1) $display("FAIL bounce_hi_back: got %b want 1", gate_hi); else n_pass++;
      end
    end
    n_checks++; if (lo_seen !== 1'b0) $display("FAIL bounce_lo_glitch: got %b want 0", lo_seen); else n_pass++;
  endtask

  task automatic test_underrun();
    ref_valid = 1'b0;
    carrier_dir = 1'b1; tick(1);
    carrier_dir = 1'b0; tick(1);
    n_checks++; if (ref_ready !== 1'b1) $display("FAIL ur_ready_valley1: got %b want 1", ref_ready); else n_pass++;
    n_checks++; if (underrun !== Dbl) $display("FAIL ur_after_valley1: got %b want %b", underrun, Dbl); else n_pass++;
    tick(5);
    n_checks++; if (ref_ready !== 1'b1) $display("FAIL ur_ready_hold: got %b want 1", ref_ready); else n_pass++;
    carrier_dir = 1'b1; tick(1);
    n_checks++; if (underrun !== Dbl) $display("FAIL ur_after_peak: got %b want %b", underrun, Dbl); else n_pass++;
    carrier_dir = 1'b0; tick(1);
    n_checks++; if (underrun !== 1'b1) $display("FAIL ur_valley2: got %b want 1", underrun); else n_pass++;
    n_checks++; if (ref_ready !== 1'b1) $display("FAIL ur_ready_stays: got %b want 1", ref_ready); else n_pass++;
    n_checks++; if (dut.ref_q !== 16'h8000) $display("FAIL ur_ref_hold: got %h want 8000", dut.ref_q); else n_pass++;
    ref_valid = 1'b1; ref_data = 16'h4000; tick(1);
    n_checks++; if (dut.ref_q !== 16'h4000) $display("FAIL ur_xfer_data: got %h want 4000", dut.ref_q); else n_pass++;
    n_checks++; if (ref_ready !== 1'b0) $display("FAIL ur_xfer_ready: got %b want 0", ref_ready); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else n_pass++;
    ref_data = 16'h1234; tick(1);
    n_checks++; if (dut.ref_q !== 16'h4000) $display("FAIL ur_ignore_valid: got %h want 4000", dut.ref_q); else n_pass++;
    ref_valid = 1'b0;
    carrier_dir = 1'b1; tick(1);
    carrier_dir = 1'b0; tick(1);
    carrier_dir = 1'b1; tick(1);
    carrier_dir = 1'b0; underrun_clr = 1'b1; tick(1);
    underrun_clr = 1'b0;
    n_checks++; if (underrun !== 1'b0) $display("FAIL ur_clr_wins: got %b want 0", underrun); else n_pass++;
    n_checks++; if (ref_ready !== 1'b1) $display("FAIL ur_clr_ready: got %b want 1", ref_ready); else n_pass++;
    ref_valid = 1'b1; ref_data = 16'h9000; tick(1);
    ref_valid = 1'b0;
    n_checks++; if (dut.ref_q !== 16'h9000) $display("FAIL ur_final_xfer: got %h want 9000", dut.ref_q); else n_pass++;
  endtask

  task automatic test_enable();
    n_checks++; if (gate_hi !== 1'b1) $display("FAIL en_pre_hi: got %b want 1", gate_hi); else n_pass++;
    enable = 1'b0; tick(1);
    n_checks++; if (gate_hi !== 1'b0) $display("FAIL en_off_hi: got %b want 0", gate_hi); else n_pass++;
    n_checks++; if (dut.u_deadtime.state_q !== StOff)
      $display("FAIL en_off_state: got %0d want %0d", dut.u_deadtime.state_q, StOff); else n_pass++;
    n_checks++; if (dut.u_deadtime.cnt_q !== 8'd0) $display("FAIL en_off_cnt: got %0d want 0", dut.u_deadtime.cnt_q); else n_pass++;
    tick(3);
    enable = 1'b1; tick(1);
    n_checks++; if (dut.u_deadtime.state_q !== StDtHi)
      $display("FAIL en_reenter_dthi: got %0d want %0d", dut.u_deadtime.state_q, StDtHi); else n_pass++;
    tick(49);
    n_checks++; if (gate_hi !== 1'b0) $display("FAIL en_dt_hold: got %b want 0", gate_hi); else n_pass++;
    tick(1);
    n_checks++; if (gate_hi !== 1'b1) $display("FAIL en_hi_after_dt: got %b want 1", gate_hi); else n_pass++;
  endtask

  task automatic test_async_reset();
    carrier = 16'hF000;
    carrier_dir = 1'b1; tick(1);
    carrier_dir = 1'b0; tick(1);
    carrier_dir = 1'b1; tick(1);
    carrier_dir = 1'b0; tick(1);
    tick(56);
    n_checks++; if (gate_lo !== 1'b1) $display("FAIL ar_pre_lo: got %b want 1", gate_lo); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL ar_pre_underrun: got %b want 1", underrun); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (gate_lo !== 1'b0) $display("FAIL ar_gate_lo: got %b want 0", gate_lo); else n_pass++;
    n_checks++; if (gate_hi !== 1'b0) $display("FAIL ar_gate_hi: got %b want 0", gate_hi); else n_pass++;
    n_checks++; if (ref_ready !== 1'b0) $display("FAIL ar_ready: got %b want 0", ref_ready); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL ar_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (dut.ref_q !== 16'h8000) $display("FAIL ar_ref_q: got %h want 8000", dut.ref_q); else n_pass++;
    n_checks++; if (dut.u_deadtime.state_q !== StOff)
      $display("FAIL ar_state: got %0d want %0d", dut.u_deadtime.state_q, StOff); else n_pass++;
  endtask

  task automatic test_update_points();
    carrier = 16'h1000;
    carrier_dir = 1'b0;
    enable = 1'b1;
    ref_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    carrier_dir = 1'b1; tick(1);
    n_checks++; if (ref_ready !== Dbl) $display("FAIL up_peak_ready: got %b want %b", ref_ready, Dbl); else n_pass++;
    ref_valid = 1'b1; ref_data = 16'h2222; tick(1);
    ref_valid = 1'b0;
    n_checks++; if (dut.ref_q !== (Dbl ? 16'h2222 : 16'h8000))
      $display("FAIL up_peak_xfer: got %h want %h", dut.ref_q, Dbl ? 16'h2222 : 16'h8000); else n_pass++;
    carrier_dir = 1'b0; tick(1);
    n_checks++; if (ref_ready !== 1'b1) $display("FAIL up_valley_ready: got %b want 1", ref_ready); else n_pass++;
    ref_valid = 1'b1; ref_data = 16'h3333; tick(1);
    ref_valid = 1'b0;
    n_checks++; if (dut.ref_q !== 16'h3333) $display("FAIL up_valley_xfer: got %h want 3333", dut.ref_q); else n_pass++;
    n_checks++; if (ref_ready !== 1'b0) $display("FAIL up_valley_drop: got %b want 0", ref_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_bounce();
    test_underrun();
    test_enable();
    test_async_reset();
    test_update_points();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
